// File: rtl/tpu_pkg.sv
// Shared TPU instruction types: the 80-bit instruction word and its idle value.
package tpu_pkg;
    localparam int INSTR_WIDTH = 80;
    typedef logic [INSTR_WIDTH-1:0] instr_type;
    localparam instr_type INIT_INSTR = '0;
endpackage

// File: rtl/instruction_fifo_mem.sv
// Instruction storage for instruction_fifo: DEPTH x 80 register array with
// one synchronous write port and one combinational read port.
module fifo_mem
    import tpu_pkg::*;
#(
    parameter int DEPTH  = 32,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              write_en,
    input  logic [ADDR_W-1:0] write_addr,
    input  instr_type         write_data,
    input  logic [ADDR_W-1:0] read_addr,
    output instr_type         read_data
);

    instr_type mem [DEPTH];

    // Contents are deliberately not reset; validity is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (write_en) begin
            mem[write_addr] <= write_data;
        end
    end

    assign read_data = mem[read_addr];

endmodule

// File: rtl/instruction_fifo.sv
// Instruction FIFO between the host word writes and the control coordinator.
// Optional macro INSTR_FIFO_ERR_EN adds a sticky overflow_err output.
//
//   state | meaning
//   IDLE  | wait for a stored entry and coordinator not busy
//   ISSUE | instr_enable high, head entry popped at end of cycle
//   WAIT  | one-cycle gap so the coordinator's busy can update
module instruction_fifo
    import tpu_pkg::*;
#(
    parameter int FIFO_DEPTH = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [31:0]                 lower_word,
    input  logic                        lower_write_en,
    input  logic [31:0]                 middle_word,
    input  logic                        middle_write_en,
    input  logic [15:0]                 upper_word,
    input  logic                        upper_write_en,
    input  logic                        busy,
`ifdef INSTR_FIFO_ERR_EN
    output logic                        overflow_err,
`endif
    output instr_type                   instr,
    output logic                        instr_enable,
    output logic                        empty,
    output logic                        full,
    output logic [$clog2(FIFO_DEPTH):0] count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
    localparam logic [AW:0]   CNT_MAX = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t       state;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [31:0]  lower_q;
    logic [31:0]  middle_q;
    logic         push;
    logic         pop;
    instr_type    push_data;
    instr_type    head;

    assign empty = (count == '0);
    assign full  = (count == CNT_MAX);
    assign push  = upper_write_en && !full;
    assign pop   = (state == ISSUE);

    // Same-cycle lower/middle writes bypass the staging registers.
    assign push_data = {upper_word,
                        middle_write_en ? middle_word : middle_q,
                        lower_write_en  ? lower_word  : lower_q};

    assign instr = empty ? INIT_INSTR : head;

    fifo_mem #(.DEPTH(FIFO_DEPTH), .ADDR_W(AW)) u_mem (
        .clk        (clk),
        .write_en   (push && !rst),
        .write_addr (wr_ptr),
        .write_data (push_data),
        .read_addr  (rd_ptr),
        .read_data  (head)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            lower_q  <= '0;
            middle_q <= '0;
        end else begin
            if (lower_write_en)  lower_q  <= lower_word;
            if (middle_write_en) middle_q <= middle_word;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // ISSUE is only entered with a stored entry, so pop never underflows.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            instr_enable <= 1'b0;
        end else begin
            instr_enable <= 1'b0;
            case (state)
                IDLE: begin
                    if (!empty && !busy) begin
                        state        <= ISSUE;
                        instr_enable <= 1'b1;
                    end
                end
                ISSUE:   state <= WAIT;
                WAIT:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef INSTR_FIFO_ERR_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_err <= 1'b0;
        end else if (upper_write_en && full) begin
            overflow_err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_instruction_fifo.sv
// Self-checking bench for instruction_fifo: a directed vector table plus
// hand-written sequences for backpressure, overflow, pointer wrap and reset.
module tb_instruction_fifo;
    localparam int DEPTH = 8;
    localparam int AW    = $clog2(DEPTH);

    logic          clk = 1'b0;
    logic          rst;
    logic [31:0]   lower_word, middle_word;
    logic [15:0]   upper_word;
    logic          lower_write_en, middle_write_en, upper_write_en, busy;
    logic [79:0]   instr;
    logic          instr_enable, empty, full;
    logic [AW:0]   count;
`ifdef INSTR_FIFO_ERR_EN
    logic          overflow_err;
`endif

    int checks = 0;
    int errors = 0;

    instruction_fifo #(.FIFO_DEPTH(DEPTH)) dut (
`ifdef INSTR_FIFO_ERR_EN
        .overflow_err    (overflow_err),
`endif
        .clk             (clk),
        .rst             (rst),
        .lower_word      (lower_word),
        .lower_write_en  (lower_write_en),
        .middle_word     (middle_word),
        .middle_write_en (middle_write_en),
        .upper_word      (upper_word),
        .upper_write_en  (upper_write_en),
        .busy            (busy),
        .instr           (instr),
        .instr_enable    (instr_enable),
        .empty           (empty),
        .full            (full),
        .count           (count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [31:0] lw;
        logic        lwe;
        logic [31:0] mw;
        logic        mwe;
        logic [15:0] uw;
        logic        uwe;
        logic        bsy;
        logic        ie;
        logic        emp;
        logic        ful;
        logic [AW:0] cnt;
        logic [79:0] ins;
    } vec_t;

    vec_t vecs [15];

    function automatic vec_t mkv(input logic r, input logic [31:0] lw, input logic lwe,
                                 input logic [31:0] mw, input logic mwe,
                                 input logic [15:0] uw, input logic uwe, input logic bsy,
                                 input logic ie, input logic emp, input logic ful,
                                 input int cnt, input logic [79:0] ins);
        vec_t v;
        v.rst = r;  v.lw = lw; v.lwe = lwe; v.mw = mw; v.mwe = mwe;
        v.uw = uw;  v.uwe = uwe; v.bsy = bsy;
        v.ie = ie;  v.emp = emp; v.ful = ful; v.cnt = (AW+1)'(cnt); v.ins = ins;
        return v;
    endfunction

    function automatic logic [79:0] make_instr(input int t);
        logic [15:0] u;
        logic [31:0] m;
        logic [31:0] l;
        u = 16'h3000 + 16'(t);
        m = 32'h1000_0000 + 32'(t);
        l = 32'h2000_0000 + 32'(t);
        return {u, m, l};
    endfunction

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        lower_write_en = 1'b0; middle_write_en = 1'b0; upper_write_en = 1'b0;
        lower_word = '0; middle_word = '0; upper_word = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        busy = 1'b1;
        rst  = 1'b1;
        @(posedge clk); #1;
        rst  = 1'b0;
    endtask

    task automatic drive_push(input int t);
        logic [79:0] w;
        w = make_instr(t);
        lower_word  = w[31:0];  lower_write_en  = 1'b1;
        middle_word = w[63:32]; middle_write_en = 1'b1;
        upper_word  = w[79:64]; upper_write_en  = 1'b1;
    endtask

    task automatic push(input int t);
        drive_push(t);
        @(posedge clk); #1;
        idle_inputs();
    endtask

    task automatic wait_ie(input int max_cycles, output bit got);
        got = 1'b0;
        for (int c = 0; c < max_cycles; c++) begin
            @(posedge clk); #1;
            if (instr_enable) begin
                got = 1'b1;
                break;
            end
        end
    endtask

    localparam logic [79:0] I1 = 80'h0800_00000500_00000A30;
    localparam logic [79:0] I2 = 80'h0033_00002222_00001111;
    localparam logic [79:0] I3 = 80'h0055_00002222_00004444;

    initial begin
        bit got;
        int n, last, strobes;
        logic [79:0] q [$];
        int next_tag;

        vecs[0]  = mkv(1, 0, 0, 0, 0, 0, 0, 1,              0, 1, 0, 0, '0);
        vecs[1]  = mkv(0, 32'h00000A30, 1, 0, 0, 0, 0, 0,   0, 1, 0, 0, '0);
        vecs[2]  = mkv(0, 0, 0, 32'h00000500, 1, 0, 0, 0,   0, 1, 0, 0, '0);
        vecs[3]  = mkv(0, 0, 0, 0, 0, 16'h0800, 1, 0,       0, 0, 0, 1, I1);
        vecs[4]  = mkv(0, 0, 0, 0, 0, 0, 0, 0,              1, 0, 0, 1, I1);
        vecs[5]  = mkv(0, 0, 0, 0, 0, 0, 0, 0,              0, 1, 0, 0, '0);
        vecs[6]  = mkv(0, 0, 0, 0, 0, 0, 0, 0,              0, 1, 0, 0, '0);
        vecs[7]  = mkv(0, 32'h1111, 1, 32'h2222, 1, 16'h0033, 1, 1, 0, 0, 0, 1, I2);
        vecs[8]  = mkv(0, 32'h4444, 1, 0, 0, 16'h0055, 1, 1, 0, 0, 0, 2, I2);
        vecs[9]  = mkv(0, 0, 0, 0, 0, 0, 0, 0,              1, 0, 0, 2, I2);
        vecs[10] = mkv(0, 0, 0, 0, 0, 0, 0, 1,              0, 0, 0, 1, I3);
        vecs[11] = mkv(0, 0, 0, 0, 0, 0, 0, 1,              0, 0, 0, 1, I3);
        vecs[12] = mkv(0, 0, 0, 0, 0, 0, 0, 0,              1, 0, 0, 1, I3);
        vecs[13] = mkv(0, 0, 0, 0, 0, 0, 0, 0,              0, 1, 0, 0, '0);
        vecs[14] = mkv(0, 0, 0, 0, 0, 0, 0, 0,              0, 1, 0, 0, '0);

        idle_inputs();
        busy = 1'b1;
        rst  = 1'b1;
        #1;

        // Vector table: inputs applied for one edge, outputs checked just after it.
        for (int i = 0; i < 15; i++) begin
            rst = vecs[i].rst;
            lower_word  = vecs[i].lw; lower_write_en  = vecs[i].lwe;
            middle_word = vecs[i].mw; middle_write_en = vecs[i].mwe;
            upper_word  = vecs[i].uw; upper_write_en  = vecs[i].uwe;
            busy = vecs[i].bsy;
            @(posedge clk); #1;
            chk($sformatf("vec%0d instr_enable", i), 80'(instr_enable), 80'(vecs[i].ie));
            chk($sformatf("vec%0d empty", i),        80'(empty),        80'(vecs[i].emp));
            chk($sformatf("vec%0d full", i),         80'(full),         80'(vecs[i].ful));
            chk($sformatf("vec%0d count", i),        80'(count),        80'(vecs[i].cnt));
            chk($sformatf("vec%0d instr", i),        instr,             vecs[i].ins);
        end
        idle_inputs();

        // Reset with no writes: nothing ever issues.
        do_reset();
        busy = 1'b0;
        strobes = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            if (instr_enable) strobes++;
        end
        chk("idle strobes", 80'(strobes), 80'(0));
        chk("idle empty", 80'(empty), 80'(1));
        chk("idle full", 80'(full), 80'(0));
        chk("idle count", 80'(count), 80'(0));
`ifdef INSTR_FIFO_ERR_EN
        chk("idle overflow_err", 80'(overflow_err), 80'(0));
`endif

        // Backpressure: three entries held while busy, then issued 3 cycles apart.
        do_reset();
        for (int t = 0; t < 3; t++) push(t);
        @(posedge clk); #1;
        chk("busy count", 80'(count), 80'(3));
        chk("busy no strobe", 80'(instr_enable), 80'(0));
        busy = 1'b0;
        n = 0; last = 0;
        for (int c = 0; c < 40 && n < 3; c++) begin
            @(posedge clk); #1;
            if (instr_enable) begin
                chk($sformatf("burst instr %0d", n), instr, make_instr(n));
                if (n > 0) chk($sformatf("burst spacing %0d", n), 80'(c - last), 80'(3));
                last = c;
                n++;
            end
        end
        chk("burst strobes", 80'(n), 80'(3));

        // Overflow: DEPTH+1 pushes while busy, plus a write during the first ISSUE.
        do_reset();
        for (int t = 0; t <= DEPTH; t++) push(t);
        chk("ovf full", 80'(full), 80'(1));
        chk("ovf count", 80'(count), 80'(DEPTH));
`ifdef INSTR_FIFO_ERR_EN
        chk("ovf overflow_err", 80'(overflow_err), 80'(1));
`endif
        busy = 1'b0;
        wait_ie(10, got);
        chk("ovf first strobe", 80'(got), 80'(1));
        chk("ovf drain 0", instr, make_instr(0));
        push(99);
        chk("ovf drop during pop", 80'(count), 80'(DEPTH - 1));
        n = 1;
        for (int c = 0; c < 10 * DEPTH && n < DEPTH + 1; c++) begin
            @(posedge clk); #1;
            if (instr_enable) begin
                if (n < DEPTH) chk($sformatf("ovf drain %0d", n), instr, make_instr(n));
                else           chk("ovf extra strobe", 80'(1), 80'(0));
                n++;
            end
        end
        chk("ovf drained", 80'(n), 80'(DEPTH));
        chk("ovf empty", 80'(empty), 80'(1));

        // Steady state: push on every issue cycle so count holds and pointers wrap.
        do_reset();
        push(100);
        push(101);
        q.push_back(make_instr(100));
        q.push_back(make_instr(101));
        next_tag = 102;
        busy = 1'b0;
        n = 0;
        got = 1'b0;
        for (int c = 0; c < 20 * DEPTH && (n < 2 * DEPTH || got); c++) begin
            @(posedge clk); #1;
            if (got) begin
                idle_inputs();
                chk($sformatf("wrap count %0d", n), 80'(count), 80'(2));
                got = 1'b0;
            end
            if (instr_enable && n < 2 * DEPTH) begin
                chk($sformatf("wrap instr %0d", n), instr, q.pop_front());
                drive_push(next_tag);
                q.push_back(make_instr(next_tag));
                next_tag++;
                n++;
                got = 1'b1;
            end
        end
        idle_inputs();
        chk("wrap pops", 80'(n), 80'(2 * DEPTH));

        // Reset during ISSUE with two entries: contents abandoned, no pop completes.
        do_reset();
        push(200);
        push(201);
        busy = 1'b0;
        wait_ie(10, got);
        chk("rst issue reached", 80'(got), 80'(1));
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst count", 80'(count), 80'(0));
        chk("rst empty", 80'(empty), 80'(1));
        chk("rst full", 80'(full), 80'(0));
        chk("rst instr_enable", 80'(instr_enable), 80'(0));
        chk("rst instr", instr, 80'(0));
        strobes = 0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            if (instr_enable) strobes++;
        end
        chk("rst no strobes", 80'(strobes), 80'(0));
        push(202);
        wait_ie(10, got);
        chk("rst reissue strobe", 80'(got), 80'(1));
        chk("rst reissue instr", instr, make_instr(202));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
